fetch_pc_gen: RTL and testbench
===============================

Name: fetch_pc_gen

Overview:
Instruction-fetch address generator for the myCPU front end. It consumes byte-address branch/jump targets that already carry the word-offset<<2 scaling, checks their alignment, and drops the two zero LSBs. It then issues word-indexed fetch requests over a valid/ready handshake. The block owns the PC register and handles MIPS branch-delay-slot sequencing, exception and ERET redirects, and misaligned-target address errors (AdEL).

Parameters:
RESET_PC, 32'hBFC0_0000, byte address of the first fetch after reset
EXC_PC, 32'hBFC0_0380, byte address of the general exception vector

Ports:
clk  in  1  system clock; all logic on rising edge
resetn  in  1  synchronous reset, active-low
stall  in  1  back-end stall; while 1, no request is offered and no PC advance occurs
br_valid  in  1  one-cycle pulse: taken branch/jump resolved in ID
br_target  in  32  byte target address of that branch/jump
exc_valid  in  1  one-cycle pulse: exception commit, redirect to EXC_PC
eret_valid  in  1  one-cycle pulse: ERET commit, redirect to epc
epc  in  32  return byte address for ERET
req_valid  out  1  fetch request valid
req_ready  in  1  instruction memory accepts request
req_word_addr  out  30  word address = pc[31:2]
pc_out  out  32  byte PC of the currently presented request (pc[1:0] always 2'b00)
in_delay_slot  out  1  presented request is a branch delay slot
adel  out  1  one-cycle pulse: misaligned redirect target detected
badvaddr  out  32  offending target of the most recent adel

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=BOOT, pc=RESET_PC.
  - req_valid=0, in_delay_slot=0, adel=0, badvaddr=0.
  - Pending-redirect register is cleared.
  - Reset mid-operation discards any pending redirect.
- States:
  - BOOT: req_valid=0. Goes to RUN on the first cycle with resetn=1.
  - RUN: req_valid = !stall. No redirect is pending.
  - PEND: req_valid = !stall. A branch target is held; the presented request is the delay slot, so in_delay_slot=1.
- Accept = req_valid & req_ready. Only an accept advances pc.
- Handshake: while req_valid=1 and not accepted, req_word_addr stays stable. The only exception is a redirect by exc_valid, eret_valid, or adel, which flushes the request.
- RUN + accept, no event: pc <= pc+4. Wraps mod 2^32.
- br_valid, target[1:0]==0:
  - The presented or next-presented request is the delay slot.
  - If an accept occurs in the same cycle: pc <= br_target, stay RUN.
  - Otherwise: latch the target and go to PEND.
  - PEND + accept: pc <= latched target, go to RUN.
- br_valid, target[1:0]!=0:
  - adel=1 the next cycle, badvaddr <= br_target, pc <= EXC_PC, go to RUN.
  - The pending redirect is cleared; the delay slot is not fetched.
- eret_valid: pc <= epc, clear pending, go to RUN. If epc[1:0]!=0, handle as AdEL instead (adel, badvaddr=epc, pc=EXC_PC).
- exc_valid: pc <= EXC_PC, clear pending, go to RUN. Redirect takes effect the next cycle, regardless of req_ready.
- Priority when simultaneous: exc_valid > eret_valid > br_valid. A lower-priority event in the same cycle is dropped.
- A br_valid while already in PEND is a protocol error: it is ignored and the first target wins.
- Stall: no accept, pc and state hold. A redirect event during stall still updates pc/pending as above.
- Latency:
  - Redirect to the new req_word_addr is 1 cycle.
  - adel pulses exactly 1 cycle after the offending input.
  - in_delay_slot is a registered version of state==PEND.

Test Plan:
- Reset release with req_ready=1 constantly → cycle 1 req_valid=0 (BOOT). Word addresses then run 0x2FF00000, 0x2FF00001, 0x2FF00002… (bytes BFC00000, +4, +8).
- br_valid with target 0xBFC00100 while the request at BFC00008 is waiting (req_ready=0 for 3 cycles) → BFC00008 is held stable with in_delay_slot=1. After its accept the next request is word 0x2FF00040, with in_delay_slot=0.
- br_valid with target 0xBFC00102 → next cycle adel=1 for one cycle, badvaddr=0xBFC00102, pc_out=0xBFC00380. The delay slot is not fetched and no request goes to word 0x2FF00040.
- exc_valid, eret_valid (epc=0x80001000) and br_valid asserted in the same cycle → pc_out=0xBFC00380, no adel, the branch is dropped. A later eret_valid alone gives pc_out=0x80001000.
- pc=0xFFFFFFFC accepted → next pc_out=0x00000000. Then stall=1 for 4 cycles → req_valid=0 and pc unchanged throughout.
- In PEND with target 0x80000040 latched, resetn=0 for one cycle → after release, fetch resumes at RESET_PC and the target 0x80000040 never appears.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// Instruction-fetch PC generator: owns the fetch PC, sequences MIPS branch delay slots,
// applies exception/ERET redirects and flags misaligned redirect targets (AdEL).
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] EXC_PC   = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_valid,
  input  logic        eret_valid,
  input  logic [31:0] epc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [29:0] req_word_addr,
  output logic [31:0] pc_out,
  output logic        in_delay_slot,
  output logic        adel,
  output logic [31:0] badvaddr
);

  localparam int unsigned WORD_W = 30;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   pc_word, pc_word_nxt;
  logic [WORD_W-1:0]   pend_word, pend_word_nxt;
  logic                adel_nxt;
  logic [31:0]         badvaddr_nxt;
  logic                accept;
  logic                br_misaligned;
  logic                epc_misaligned;

  // PC is kept as a word index so the two zero LSBs can never be set.
  assign req_valid      = (state != BOOT) && !stall;
  assign accept         = req_valid && req_ready;
  assign req_word_addr  = pc_word;
  assign pc_out         = {pc_word, 2'b00};
  assign br_misaligned  = (br_target[1:0] != 2'b00);
  assign epc_misaligned = (epc[1:0] != 2'b00);

  // State, PC and pending-target registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= BOOT;
      pc_word       <= RESET_PC[31:2];
      pend_word     <= '0;
      in_delay_slot <= 1'b0;
      adel          <= 1'b0;
      badvaddr      <= '0;
    end else begin
      state         <= state_nxt;
      pc_word       <= pc_word_nxt;
      pend_word     <= pend_word_nxt;
      in_delay_slot <= (state_nxt == PEND);
      adel          <= adel_nxt;
      badvaddr      <= badvaddr_nxt;
    end
  end

  // Next-state: redirects by priority exc > eret > branch, then normal sequencing
  always_comb begin
    state_nxt     = state;
    pc_word_nxt   = pc_word;
    pend_word_nxt = pend_word;
    adel_nxt      = 1'b0;
    badvaddr_nxt  = badvaddr;

    if (exc_valid) begin
      state_nxt     = RUN;
      pc_word_nxt   = EXC_PC[31:2];
      pend_word_nxt = '0;
    end else if (eret_valid) begin
      state_nxt     = RUN;
      pend_word_nxt = '0;
      if (epc_misaligned) begin
        adel_nxt     = 1'b1;
        badvaddr_nxt = epc;
        pc_word_nxt  = EXC_PC[31:2];
      end else begin
        pc_word_nxt = epc[31:2];
      end
    end else begin
      case (state)
        BOOT: begin
          state_nxt = RUN;
        end
        RUN: begin
          if (br_valid && br_misaligned) begin
            // Faulting target: the delay slot is abandoned along with the branch
            adel_nxt      = 1'b1;
            badvaddr_nxt  = br_target;
            pc_word_nxt   = EXC_PC[31:2];
            pend_word_nxt = '0;
          end else if (br_valid) begin
            if (accept) begin
              pc_word_nxt = br_target[31:2];
            end else begin
              pend_word_nxt = br_target[31:2];
              state_nxt     = PEND;
            end
          end else if (accept) begin
            pc_word_nxt = pc_word + WORD_W'(1);
          end
        end
        PEND: begin
          // A second branch here is a protocol error; the held target wins.
          if (accept) begin
            pc_word_nxt   = pend_word;
            pend_word_nxt = '0;
            state_nxt     = RUN;
          end
        end
        default: begin
          state_nxt = BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: linear sequence of steps with hand-computed expectations.
module tb_fetch_pc_gen;

  logic        clk;
  logic        resetn;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_valid;
  logic        eret_valid;
  logic [31:0] epc;
  logic        req_valid;
  logic        req_ready;
  logic [29:0] req_word_addr;
  logic [31:0] pc_out;
  logic        in_delay_slot;
  logic        adel;
  logic [31:0] badvaddr;

  int checks = 0;
  int errors = 0;

  fetch_pc_gen dut (
    .clk           (clk),
    .resetn        (resetn),
    .stall         (stall),
    .br_valid      (br_valid),
    .br_target     (br_target),
    .exc_valid     (exc_valid),
    .eret_valid    (eret_valid),
    .epc           (epc),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_word_addr (req_word_addr),
    .pc_out        (pc_out),
    .in_delay_slot (in_delay_slot),
    .adel          (adel),
    .badvaddr      (badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; stall = 1'b0; br_valid = 1'b0; br_target = '0;
    exc_valid = 1'b0; eret_valid = 1'b0; epc = '0; req_ready = 1'b1;
    step(); step();
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_ds", {31'd0, in_delay_slot}, 32'd0);
    chk("rst_adel", {31'd0, adel}, 32'd0);
    chk("rst_badvaddr", badvaddr, 32'h0);
    chk("rst_pc", pc_out, 32'hBFC0_0000);

    // Release: one BOOT cycle without a request
    resetn = 1'b1; #1;
    chk("boot_req_valid", {31'd0, req_valid}, 32'd0);
    step();
    chk("run_req_valid", {31'd0, req_valid}, 32'd1);
    chk("word0", {2'b00, req_word_addr}, 32'h2FF0_0000);
    step();
    chk("word1", {2'b00, req_word_addr}, 32'h2FF0_0001);
    step();
    chk("word2", {2'b00, req_word_addr}, 32'h2FF0_0002);

    // Aligned branch while BFC00008 waits three cycles
    req_ready = 1'b0; br_valid = 1'b1; br_target = 32'hBFC0_0100; #1;
    chk("br_cyc_pc", pc_out, 32'hBFC0_0008);
    step(); br_valid = 1'b0; br_target = '0; #1;
    chk("pend1_pc", pc_out, 32'hBFC0_0008);
    chk("pend1_ds", {31'd0, in_delay_slot}, 32'd1);
    chk("pend1_rv", {31'd0, req_valid}, 32'd1);
    step();
    chk("pend2_pc", pc_out, 32'hBFC0_0008);
    chk("pend2_ds", {31'd0, in_delay_slot}, 32'd1);
    req_ready = 1'b1; step();
    chk("br_tgt_word", {2'b00, req_word_addr}, 32'h2FF0_0040);
    chk("br_tgt_ds", {31'd0, in_delay_slot}, 32'd0);

    // Misaligned branch target
    req_ready = 1'b0; br_valid = 1'b1; br_target = 32'hBFC0_0102; step();
    br_valid = 1'b0; br_target = '0; #1;
    chk("adel_pulse", {31'd0, adel}, 32'd1);
    chk("adel_badv", badvaddr, 32'hBFC0_0102);
    chk("adel_pc", pc_out, 32'hBFC0_0380);
    chk("adel_ds", {31'd0, in_delay_slot}, 32'd0);
    req_ready = 1'b1; step();
    chk("adel_gone", {31'd0, adel}, 32'd0);
    chk("after_adel_pc", pc_out, 32'hBFC0_0384);

    // exc + eret + branch together: exception wins, others dropped
    exc_valid = 1'b1; eret_valid = 1'b1; epc = 32'h8000_1000;
    br_valid = 1'b1; br_target = 32'hBFC0_0200; step();
    exc_valid = 1'b0; eret_valid = 1'b0; br_valid = 1'b0; req_ready = 1'b0; #1;
    chk("prio_pc", pc_out, 32'hBFC0_0380);
    chk("prio_adel", {31'd0, adel}, 32'd0);
    step();
    chk("prio_ds", {31'd0, in_delay_slot}, 32'd0);
    chk("prio_hold_pc", pc_out, 32'hBFC0_0380);
    eret_valid = 1'b1; step(); eret_valid = 1'b0; #1;
    chk("eret_pc", pc_out, 32'h8000_1000);

    // Misaligned ERET return address
    eret_valid = 1'b1; epc = 32'h8000_1002; step(); eret_valid = 1'b0; #1;
    chk("eret_adel", {31'd0, adel}, 32'd1);
    chk("eret_badv", badvaddr, 32'h8000_1002);
    chk("eret_adel_pc", pc_out, 32'hBFC0_0380);

    // PC wrap, then stall holds everything
    eret_valid = 1'b1; epc = 32'hFFFF_FFFC; step(); eret_valid = 1'b0; #1;
    chk("wrap_pre", pc_out, 32'hFFFF_FFFC);
    req_ready = 1'b1; step();
    chk("wrap_post", pc_out, 32'h0000_0000);
    stall = 1'b1; #1;
    chk("stall0_rv", {31'd0, req_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_rv", {31'd0, req_valid}, 32'd0);
      chk("stall_pc", pc_out, 32'h0000_0000);
    end
    stall = 1'b0; #1;
    chk("unstall_rv", {31'd0, req_valid}, 32'd1);
    step();
    chk("unstall_pc", pc_out, 32'h0000_0004);

    // Second branch in PEND is ignored
    req_ready = 1'b0; br_valid = 1'b1; br_target = 32'h8000_0080; step();
    br_target = 32'h9000_0000; step();
    br_valid = 1'b0; req_ready = 1'b1; #1;
    chk("dup_ds", {31'd0, in_delay_slot}, 32'd1);
    chk("dup_pc", pc_out, 32'h0000_0004);
    step();
    chk("dup_first_wins", pc_out, 32'h8000_0080);

    // Reset while PEND discards the held target
    req_ready = 1'b0; br_valid = 1'b1; br_target = 32'h8000_0040; step();
    br_valid = 1'b0; #1;
    chk("pend_before_rst", {31'd0, in_delay_slot}, 32'd1);
    resetn = 1'b0; step();
    resetn = 1'b1; req_ready = 1'b1; #1;
    chk("rst_pend_rv", {31'd0, req_valid}, 32'd0);
    chk("rst_pend_ds", {31'd0, in_delay_slot}, 32'd0);
    step();
    chk("resume_pc0", pc_out, 32'hBFC0_0000);
    step();
    chk("resume_pc1", pc_out, 32'hBFC0_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
